formula_n_isqrt_fsm: RTL and testbench
======================================

// Module: formula_n_isqrt_fsm
// PURPOSE
//  Parametrised successor to the three-argument formula FSMs.
//  Evaluates one of two formulas over N_ARGS unsigned arguments, chosen per transaction:
//  - sum:    isqrt(a0) + ... + isqrt(aN-1)
//  - nested: isqrt(a0 + isqrt(a1 + ... isqrt(aN-1)))
//  Drives a single shared, externally instantiated isqrt block via valid-qualified request/response ports.
//  Sits between a request source and the shared isqrt, as formula_1/formula_2 FSMs do.
// PARAMETERS
//  N_ARGS  3   number of arguments, >= 2
//  WIDTH   32  argument width, even
//  X_W     WIDTH+1                 isqrt operand width (holds arg + previous root)
//  Y_W     WIDTH/2+1               isqrt result width
//  RES_W   Y_W+$clog2(N_ARGS)      result width
// PORTS
//  clk          input   1             clock, all logic on posedge
//  rst          input   1             reset, synchronous, active-low (0 = reset)
//  arg_vld      input   1             request strobe
//  mode         input   1             0 = sum, 1 = nested; sampled with arg_vld
//  args         input   N_ARGS*WIDTH  packed arguments, arg i = args[i*WIDTH +: WIDTH]
//  busy         output  1             transaction in progress, new requests ignored
//  res_vld      output  1             one-cycle result strobe
//  res          output  RES_W         result, valid when res_vld
//  isqrt_x_vld  output  1             isqrt request strobe
//  isqrt_x      output  X_W           isqrt operand
//  isqrt_y_vld  input   1             isqrt response strobe
//  isqrt_y      input   Y_W           isqrt result
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - state=IDLE; busy, res_vld, isqrt_x_vld = 0; res, isqrt_x, accumulator, index = 0.
//  - Reset mid-transaction aborts it; no res_vld is produced for it.
//  FSM states: IDLE, ISSUE, WAIT.
//  - IDLE: arg_vld=1 latches args and mode, loads index, clears acc, goes to ISSUE.
//    - Index starts at 0 (sum) or N_ARGS-1 (nested).
//  - ISSUE (one cycle): isqrt_x_vld=1, then go to WAIT.
//    - sum: isqrt_x = zero-extended arg[idx].
//    - nested: isqrt_x = arg[idx] + acc (X_W bits, no overflow); acc=0 for the first issue.
//  - WAIT: hold until isqrt_y_vld=1, then update acc.
//    - sum: acc += isqrt_y.  nested: acc = isqrt_y.
//    - Last argument (sum idx==N_ARGS-1, nested idx==0): res<=acc', res_vld<=1 next cycle, go to IDLE.
//    - Otherwise step idx (+1 sum / -1 nested) and go to ISSUE.
//  busy = (state != IDLE). arg_vld while busy is dropped, with no effect on the transaction.
//  isqrt_y_vld in IDLE or ISSUE is ignored.
//  Exactly one outstanding isqrt request; isqrt_x_vld never asserted in WAIT.
//  Timing (isqrt latency L, arg_vld at edge 0):
//  - x_vld in cycles 1 + k*(L+1), k = 0..N_ARGS-1.
//  - res_vld in cycle N_ARGS*(L+1)+1.
//  res_vld cycle is IDLE: arg_vld in that cycle is accepted (back-to-back, no gap).
//  res holds its value until the next result; isqrt_x holds its value between requests.
//  Arithmetic unsigned throughout; RES_W/X_W are sized so nothing truncates.
// TESTING
//  Bench: N_ARGS=3, WIDTH=32, behavioural isqrt latency L=4, plus a random-latency isqrt (1..8).
//  1 sum: args 16,25,36 -> res_vld at cycle 16, res=15; exactly 3 isqrt_x_vld pulses, operands 16,25,36.
//  2 nested: a0=6,a1=5,a2=16 -> isqrt_x sequence 16,9,9 -> res=3.
//  3 max: all args 32'hFFFFFFFF
//    - sum -> res=196605.
//    - nested -> res=65536, isqrt_x last=33'h1_0000_FFFF.
//  4 busy: arg_vld with args 1,1,1 while a transaction runs -> ignored; original result unchanged, single res_vld.
//  5 back-to-back: new arg_vld (mode=1) in the res_vld cycle -> accepted; second result correct.
//  6 reset: rst=0 one cycle after the 2nd isqrt_x_vld -> all outputs 0; stray isqrt_y_vld ignored; no res_vld.
//    - A following transaction completes correctly.
//  Scoreboard: random args/modes vs reference model, 1000 transactions, zero mismatches.

Source files
------------

// File: rtl/formula_n_isqrt_fsm.sv
// Sequences N_ARGS arguments through one shared, externally instantiated isqrt block.
// The sum formula adds every root; the nested formula feeds each root into the next operand.
module formula_n_isqrt_fsm #(
    parameter int N_ARGS = 3,
    parameter int WIDTH  = 32,
    parameter int X_W    = WIDTH + 1,
    parameter int Y_W    = WIDTH / 2 + 1,
    parameter int RES_W  = Y_W + $clog2(N_ARGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arg_vld,
    input  logic                      mode,
    input  logic [N_ARGS*WIDTH-1:0]   args,
    output logic                      busy,
    output logic                      res_vld,
    output logic [RES_W-1:0]          res,
    output logic                      isqrt_x_vld,
    output logic [X_W-1:0]            isqrt_x,
    input  logic                      isqrt_y_vld,
    input  logic [Y_W-1:0]            isqrt_y
);

    localparam int IDX_W = $clog2(N_ARGS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ARGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                    state_q, state_d;
    logic [N_ARGS*WIDTH-1:0]   args_q, args_d;
    logic                      mode_q, mode_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [RES_W-1:0]          acc_q, acc_d;
    logic [RES_W-1:0]          res_q, res_d;
    logic                      res_vld_q, res_vld_d;
    logic [X_W-1:0]            x_q, x_d;

    logic [IDX_W-1:0]          idx_first;
    logic [IDX_W-1:0]          idx_next;
    logic [RES_W-1:0]          acc_new;
    logic                      last_arg;

    function automatic logic [WIDTH-1:0] arg_sel(input logic [N_ARGS*WIDTH-1:0] a,
                                                 input logic [IDX_W-1:0] i);
        return a[int'(i)*WIDTH +: WIDTH];
    endfunction

    // The next operand is computed on the transition into ISSUE so isqrt_x is
    // already stable while isqrt_x_vld is high and then simply holds.
    always_comb begin
        state_d   = state_q;
        args_d    = args_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        x_d       = x_q;

        idx_first = mode ? IDX_LAST : '0;
        idx_next  = mode_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
        acc_new   = mode_q ? RES_W'(isqrt_y) : (acc_q + RES_W'(isqrt_y));
        last_arg  = mode_q ? (idx_q == '0) : (idx_q == IDX_LAST);

        case (state_q)
            IDLE: begin
                if (arg_vld) begin
                    args_d  = args;
                    mode_d  = mode;
                    idx_d   = idx_first;
                    acc_d   = '0;
                    x_d     = X_W'(arg_sel(args, idx_first));
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (isqrt_y_vld) begin
                    acc_d = acc_new;
                    if (last_arg) begin
                        res_d     = acc_new;
                        res_vld_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idx_d   = idx_next;
                        x_d     = mode_q ? (X_W'(arg_sel(args_q, idx_next)) + X_W'(isqrt_y))
                                         : X_W'(arg_sel(args_q, idx_next));
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            args_q    <= '0;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            x_q       <= '0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            x_q       <= x_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign isqrt_x_vld = (state_q == ISSUE);
    assign isqrt_x     = x_q;
    assign res         = res_q;
    assign res_vld     = res_vld_q;

endmodule

// File: tb/tb_formula_n_isqrt_fsm.sv
// Directed-vector and scoreboard bench for formula_n_isqrt_fsm (N_ARGS=3, WIDTH=32)
// with a behavioural isqrt responder of fixed or random latency.
module tb_formula_n_isqrt_fsm;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int XW = W + 1;
    localparam int YW = W / 2 + 1;
    localparam int RW = YW + $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          arg_vld;
    logic          mode;
    logic [N*W-1:0] args;
    logic          busy;
    logic          res_vld;
    logic [RW-1:0] res;
    logic          isqrt_x_vld;
    logic [XW-1:0] isqrt_x;
    logic          isqrt_y_vld;
    logic [YW-1:0] isqrt_y;

    formula_n_isqrt_fsm #(
        .N_ARGS(N),
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arg_vld    (arg_vld),
        .mode       (mode),
        .args       (args),
        .busy       (busy),
        .res_vld    (res_vld),
        .res        (res),
        .isqrt_x_vld(isqrt_x_vld),
        .isqrt_x    (isqrt_x),
        .isqrt_y_vld(isqrt_y_vld),
        .isqrt_y    (isqrt_y)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    bit rand_lat = 1'b0;

    function automatic longint unsigned isq(input longint unsigned x);
        longint unsigned y = 0;
        longint unsigned t;
        for (int b = 16; b >= 0; b--) begin
            t = y | (64'd1 << b);
            if (t * t <= x) y = t;
        end
        return y;
    endfunction

    function automatic longint unsigned ref_res(input logic m, input logic [31:0] a0, a1, a2);
        if (m == 1'b0) return isq(a0) + isq(a1) + isq(a2);
        return isq(64'(a0) + isq(64'(a1) + isq(64'(a2))));
    endfunction

    // Behavioural isqrt: request seen in cycle t, response sampled at edge t+lat.
    initial begin
        longint unsigned xs;
        int lat;
        isqrt_y_vld = 1'b0;
        isqrt_y     = '0;
        forever begin
            @(negedge clk);
            if (isqrt_x_vld) begin
                xs  = 64'(isqrt_x);
                lat = rand_lat ? int'($urandom_range(1, 8)) : 4;
                repeat (lat) @(posedge clk);
                #1;
                isqrt_y     = YW'(isq(xs));
                isqrt_y_vld = 1'b1;
                @(posedge clk);
                #1 isqrt_y_vld = 1'b0;
            end
        end
    end

    // Monitor: cycle stamps of accepts, isqrt requests and results.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int            acc_cyc[$];
    int            x_cyc[$];
    logic [XW-1:0] x_ops[$];
    int            res_cyc[$];
    logic [RW-1:0] res_vals[$];

    always @(negedge clk) begin
        if (rst && arg_vld && !busy) acc_cyc.push_back(edge_cnt);
        if (isqrt_x_vld) begin
            x_cyc.push_back(edge_cnt);
            x_ops.push_back(isqrt_x);
        end
        if (res_vld) begin
            res_cyc.push_back(edge_cnt);
            res_vals.push_back(res);
        end
    end

    task automatic clear_mon();
        acc_cyc.delete();
        x_cyc.delete();
        x_ops.delete();
        res_cyc.delete();
        res_vals.delete();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic start_txn(input logic m, input logic [31:0] a0, a1, a2);
        mode    = m;
        args    = {a2, a1, a0};
        arg_vld = 1'b1;
        @(posedge clk);
        #1 arg_vld = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (res_vals.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (res_vals.size() < n) begin
            nvec++;
            nmis++;
            $display("FAIL %s: timeout, got %0d results expected %0d", name, res_vals.size(), n);
        end
    endtask

    function automatic logic [63:0] q_res(input int i);
        return (res_vals.size() > i) ? 64'(res_vals[i]) : 64'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] q_x(input int i);
        return (x_ops.size() > i) ? 64'(x_ops[i]) : 64'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] res_lat(input int i);
        return (res_cyc.size() > i && acc_cyc.size() > i) ? 64'(res_cyc[i] - acc_cyc[i]) : 64'hDEAD_BEEF;
    endfunction

    typedef struct {
        string          name;
        logic           m;
        logic [31:0]    a0, a1, a2;
        logic [RW-1:0]  exp_res;
        logic [XW-1:0]  x0, x1, x2;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] r0, r1, r2;
        logic        rm;
        int          gap;

        tbl[0] = '{"sum_small",  1'b0, 32'd16, 32'd25, 32'd36, 19'd15,     33'd16, 33'd25, 33'd36};
        tbl[1] = '{"nested_sm",  1'b1, 32'd6,  32'd5,  32'd16, 19'd3,      33'd16, 33'd9,  33'd9};
        tbl[2] = '{"sum_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 19'd196605,
                   33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF};
        tbl[3] = '{"nested_max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 19'd65536,
                   33'h0_FFFF_FFFF, 33'h1_0000_FFFE, 33'h1_0000_FFFF};

        rst     = 1'b0;
        arg_vld = 1'b0;
        mode    = 1'b0;
        args    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    64'(busy), 0);
        check("rst_res_vld", 64'(res_vld), 0);
        check("rst_x_vld",   64'(isqrt_x_vld), 0);
        check("rst_res",     64'(res), 0);
        check("rst_x",       64'(isqrt_x), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table with fixed isqrt latency 4.
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            start_txn(tbl[i].m, tbl[i].a0, tbl[i].a1, tbl[i].a2);
            wait_results(1, tbl[i].name);
            repeat (4) @(posedge clk);
            #1;
            check({tbl[i].name, "_res"},    q_res(0), 64'(tbl[i].exp_res));
            check({tbl[i].name, "_lat"},    res_lat(0), 16);
            check({tbl[i].name, "_nres"},   64'(res_vals.size()), 1);
            check({tbl[i].name, "_nx"},     64'(x_ops.size()), 3);
            check({tbl[i].name, "_x0"},     q_x(0), 64'(tbl[i].x0));
            check({tbl[i].name, "_x1"},     q_x(1), 64'(tbl[i].x1));
            check({tbl[i].name, "_x2"},     q_x(2), 64'(tbl[i].x2));
            check({tbl[i].name, "_x0cyc"},  (x_cyc.size() > 0 && acc_cyc.size() > 0) ? 64'(x_cyc[0] - acc_cyc[0]) : 64'hDEAD, 1);
            check({tbl[i].name, "_x2cyc"},  (x_cyc.size() > 2 && acc_cyc.size() > 0) ? 64'(x_cyc[2] - acc_cyc[0]) : 64'hDEAD, 11);
            check({tbl[i].name, "_hold"},   64'(res), 64'(tbl[i].exp_res));
            check({tbl[i].name, "_xhold"},  64'(isqrt_x), 64'(tbl[i].x2));
            check({tbl[i].name, "_idle"},   64'(busy), 0);
        end

        // A request while busy is dropped.
        clear_mon();
        start_txn(1'b0, 32'd16, 32'd25, 32'd36);
        repeat (3) @(posedge clk);
        #1;
        check("busy_flag", 64'(busy), 1);
        start_txn(1'b1, 32'd1, 32'd1, 32'd1);
        wait_results(1, "busy_drop");
        repeat (20) @(posedge clk);
        #1;
        check("busy_res",  q_res(0), 15);
        check("busy_nres", 64'(res_vals.size()), 1);
        check("busy_nx",   64'(x_ops.size()), 3);
        check("busy_x1",   q_x(1), 25);

        // Back-to-back: new request in the res_vld cycle.
        clear_mon();
        start_txn(1'b0, 32'd16, 32'd25, 32'd36);
        begin
            int k = 0;
            while (!res_vld && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("b2b_seen", 64'(res_vld), 1);
        end
        start_txn(1'b1, 32'd6, 32'd5, 32'd16);
        wait_results(2, "b2b");
        repeat (3) @(posedge clk);
        #1;
        check("b2b_res0", q_res(0), 15);
        check("b2b_res1", q_res(1), 3);
        check("b2b_nacc", 64'(acc_cyc.size()), 2);
        check("b2b_gap",  (acc_cyc.size() > 1 && res_cyc.size() > 0) ? 64'(acc_cyc[1] - res_cyc[0]) : 64'hDEAD, 0);
        check("b2b_lat1", res_lat(1), 16);

        // Reset one cycle after the second request aborts the transaction.
        clear_mon();
        start_txn(1'b0, 32'd16, 32'd25, 32'd36);
        begin
            int k = 0;
            while (x_ops.size() < 2 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check("rst2_nx", 64'(x_ops.size()), 2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        check("rst2_busy",    64'(busy), 0);
        check("rst2_res_vld", 64'(res_vld), 0);
        check("rst2_x_vld",   64'(isqrt_x_vld), 0);
        check("rst2_res",     64'(res), 0);
        check("rst2_x",       64'(isqrt_x), 0);
        repeat (20) @(posedge clk);
        #1;
        check("rst2_nores", 64'(res_vals.size()), 0);
        check("rst2_idle",  64'(busy), 0);
        clear_mon();
        start_txn(1'b1, 32'd6, 32'd5, 32'd16);
        wait_results(1, "rst2_after");
        check("rst2_after_res", q_res(0), 3);

        // Scoreboard with random isqrt latency.
        rand_lat = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int t = 0; t < 1000; t++) begin
            case ($urandom_range(0, 3))
                0: begin r0 = $urandom; r1 = $urandom; r2 = $urandom; end
                1: begin r0 = $urandom_range(0, 1000); r1 = $urandom_range(0, 1000); r2 = $urandom_range(0, 1000); end
                2: begin r0 = 32'hFFFF_FFFF; r1 = $urandom; r2 = 32'hFFFF_FFFF; end
                default: begin r0 = $urandom_range(0, 3); r1 = $urandom; r2 = $urandom_range(0, 65536); end
            endcase
            rm = 1'($urandom_range(0, 1));
            clear_mon();
            start_txn(rm, r0, r1, r2);
            wait_results(1, "sb");
            check("sb_res", q_res(0), ref_res(rm, r0, r1, r2));
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
